puf_response_reader: RTL and testbench

PUF_RESPONSE_READER -- requirements
Module: puf_response_reader

---
 rtl/puf_response_reader_if.sv | 30 +++
 rtl/puf_response_reader.sv | 103 ++++++++++
 tb/tb_puf_response_reader.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/puf_response_reader_if.sv
// puf_response_reader_if: handshake and PUF signal bundle for puf_response_reader.
interface puf_response_reader_if #(
    parameter int RESP_W = 1024,
    parameter int WORD_W = 32
);
    localparam int NW    = RESP_W / WORD_W;
    localparam int IDX_W = (NW > 1) ? $clog2(NW) : 1;
    localparam int CNT_W = $clog2(RESP_W) + 1;
    logic              start;
    logic [1:0]        challenge;
    logic              abort;
    logic              puf_enable;
    logic [1:0]        puf_control;
    logic [RESP_W-1:0] puf_response;
    logic [WORD_W-1:0] word_data;
    logic [IDX_W-1:0]  word_index;
    logic              word_valid;
    logic              word_ready;
    logic              busy;
    logic              done;
    logic [CNT_W-1:0]  unstable_cnt;
    modport master (
        output start, challenge, abort, puf_response, word_ready,
        input  puf_enable, puf_control, word_data, word_index, word_valid, busy, done, unstable_cnt
    );
    modport slave (
        input  start, challenge, abort, puf_response, word_ready,
        output puf_enable, puf_control, word_data, word_index, word_valid, busy, done, unstable_cnt
    );
endinterface

// File: rtl/puf_response_reader.sv
// puf_response_reader: triple-sample PUF read with bitwise majority vote and word streaming.
// Define PUF_READER_UNSTABLE_EN to count bit positions where the three samples disagree.
module puf_response_reader #(
    parameter int RESP_W     = 1024,
    parameter int WORD_W     = 32,
    parameter int SETTLE_CYC = 4
) (
    input logic                 clk,
    input logic                 rst_n,
    puf_response_reader_if.slave bus
);
    localparam int NW    = RESP_W / WORD_W;
    localparam int IDX_W = (NW > 1) ? $clog2(NW) : 1;
    typedef enum logic [2:0] {IDLE, SETTLE, CAPTURE, REST, STREAM, DONE} state_t;
    state_t            r_state, w_next;
    logic [1:0]        r_ctrl;
    logic [7:0]        r_cnt;
    logic [1:0]        r_k;
    logic [IDX_W-1:0]  r_idx;
    logic [RESP_W-1:0] r_s0, r_s1, r_result, w_maj;
    logic              w_accept, w_abort, w_settled, w_xfer, w_last;
    logic              w_en, w_valid, w_busy, w_done;
    assign w_accept  = (r_state == IDLE) && bus.start && !bus.abort;
    assign w_abort   = (r_state != IDLE) && bus.abort;
    assign w_settled = r_cnt == 8'(SETTLE_CYC - 1);
    assign w_xfer    = (r_state == STREAM) && bus.word_ready;
    assign w_last    = r_idx == IDX_W'(NW - 1);
    // third sample is voted straight from the input during the final capture
    assign w_maj = (r_s0 & r_s1) | (r_s0 & bus.puf_response) | (r_s1 & bus.puf_response);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    always_comb begin
        w_next  = r_state;
        w_en    = (r_state == SETTLE) || (r_state == CAPTURE);
        w_valid = r_state == STREAM;
        w_busy  = r_state != IDLE;
        w_done  = r_state == DONE;
        if (w_abort) w_next = IDLE;
        else begin
            case (r_state)
                IDLE:    w_next = w_accept ? SETTLE : IDLE;
                SETTLE:  w_next = w_settled ? CAPTURE : SETTLE;
                CAPTURE: w_next = (r_k == 2'd2) ? STREAM : REST;
                REST:    w_next = SETTLE;
                STREAM:  w_next = (w_xfer && w_last) ? DONE : STREAM;
                DONE:    w_next = IDLE;
                default: w_next = IDLE;
            endcase
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ctrl   <= '0;
            r_cnt    <= '0;
            r_k      <= '0;
            r_idx    <= '0;
            r_s0     <= '0;
            r_s1     <= '0;
            r_result <= '0;
        end else begin
            if (w_accept) r_ctrl <= bus.challenge;
            if (w_abort) begin
                r_cnt <= '0;
                r_k   <= '0;
                r_idx <= '0;
            end else begin
                if (r_state == SETTLE) r_cnt <= w_settled ? 8'd0 : r_cnt + 8'd1;
                if (r_state == CAPTURE) begin
                    if (r_k == 2'd0) r_s0 <= bus.puf_response;
                    if (r_k == 2'd1) r_s1 <= bus.puf_response;
                    if (r_k == 2'd2) r_result <= w_maj;
                    r_k <= (r_k == 2'd2) ? 2'd0 : r_k + 2'd1;
                end
                if (w_xfer) r_idx <= w_last ? '0 : r_idx + IDX_W'(1);
            end
        end
    end
    assign bus.puf_enable  = w_en;
    assign bus.puf_control = r_ctrl;
    assign bus.word_valid  = w_valid;
    assign bus.busy        = w_busy;
    assign bus.done        = w_done;
    assign bus.word_index  = r_idx;
    assign bus.word_data   = r_result[r_idx*WORD_W +: WORD_W];
`ifdef PUF_READER_UNSTABLE_EN
    localparam int CNT_W = $clog2(RESP_W) + 1;
    logic [CNT_W-1:0]  r_unst, w_pop;
    logic [RESP_W-1:0] w_dis;
    assign w_dis = (r_s0 ^ r_s1) | (r_s1 ^ bus.puf_response);
    always_comb begin
        w_pop = '0;
        for (int i = 0; i < RESP_W; i++) w_pop = w_pop + CNT_W'(w_dis[i]);
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)                                r_unst <= '0;
        else if (w_accept || w_abort)              r_unst <= '0;
        else if (r_state == CAPTURE && r_k == 2'd2) r_unst <= w_pop;
    assign bus.unstable_cnt = r_unst;
`else
    assign bus.unstable_cnt = '0;
`endif
endmodule

// File: tb/tb_puf_response_reader.sv
// tb_puf_response_reader: scoreboard bench for puf_response_reader.
// Runs with or without PUF_READER_UNSTABLE_EN defined.
module tb_puf_response_reader;
    localparam int RESP_W = 1024;
    localparam int WORD_W = 32;
    localparam int NW     = RESP_W / WORD_W;
    localparam int IDX_W  = 5;
`ifdef PUF_READER_UNSTABLE_EN
    localparam int EXP_UNST = 2;
`else
    localparam int EXP_UNST = 0;
`endif
    typedef struct {
        logic [IDX_W-1:0]  idx;
        logic [WORD_W-1:0] data;
    } exp_t;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_pass = 0;
    int   n_total = 0;
    exp_t sb[$];
    puf_response_reader_if #(.RESP_W(RESP_W), .WORD_W(WORD_W)) bus ();
    puf_response_reader #(.RESP_W(RESP_W), .WORD_W(WORD_W), .SETTLE_CYC(4)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );
    always #5 clk = ~clk;
    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    function automatic logic [RESP_W-1:0] build(input logic [31:0] base);
        logic [RESP_W-1:0] r;
        for (int i = 0; i < NW; i++) r[i*WORD_W +: WORD_W] = base + 32'(i);
        return r;
    endfunction
    function automatic logic [RESP_W-1:0] vote(input logic [RESP_W-1:0] a, b, c);
        logic [RESP_W-1:0] r;
        for (int i = 0; i < RESP_W; i++) r[i] = (int'(a[i]) + int'(b[i]) + int'(c[i])) >= 2;
        return r;
    endfunction
    // start a read and present a, b, c across the three captures; returns at T+17
    task automatic launch(input logic [1:0] ch, input logic [RESP_W-1:0] a, b, c);
        logic [RESP_W-1:0] m;
        m = vote(a, b, c);
        for (int i = 0; i < NW; i++) sb.push_back('{idx: IDX_W'(i), data: m[i*WORD_W +: WORD_W]});
        bus.challenge = ch;
        bus.abort = 1'b0;
        bus.start = 1'b1;
        bus.puf_response = a;
        tick();
        bus.start = 1'b0;
        bus.challenge = ~ch;
        repeat (5) tick();
        bus.puf_response = b;
        repeat (6) tick();
        bus.puf_response = c;
        repeat (5) tick();
    endtask
    // consume STREAM words against the scoreboard; optional stall or abort at given index
    task automatic drain(input int stall_at, input int stall_len, input int abort_at);
        int stalled = 0;
        bit fin = 0;
        bit last;
        for (int cyc = 0; cyc < 300 && !fin; cyc++) begin
            n_total++;
            if (bus.word_valid !== 1'b1 || sb.size() == 0) begin
                $display("FAIL stream_valid: valid=%b queued=%0d required valid=1 with queued words", bus.word_valid, sb.size());
                fin = 1;
            end else begin
                n_pass++;
                n_total++;
                if (bus.word_index !== sb[0].idx || bus.word_data !== sb[0].data) begin
                    $display("FAIL stream_word: idx=%0d data=%h required idx=%0d data=%h", bus.word_index, bus.word_data, sb[0].idx, sb[0].data);
                end else n_pass++;
                if (int'(sb[0].idx) == stall_at && stalled < stall_len) begin
                    bus.word_ready = 1'b0;
                    stalled++;
                    tick();
                end else if (int'(sb[0].idx) == abort_at) begin
                    bus.word_ready = 1'b1;
                    bus.abort = 1'b1;
                    tick();
                    bus.abort = 1'b0;
                    sb.delete();
                    n_total++;
                    if (bus.busy !== 1'b0 || bus.word_valid !== 1'b0 || bus.done !== 1'b0 || bus.puf_enable !== 1'b0) begin
                        $display("FAIL abort_exit: busy=%b valid=%b done=%b en=%b required all 0", bus.busy, bus.word_valid, bus.done, bus.puf_enable);
                    end else n_pass++;
                    tick();
                    n_total++;
                    if (bus.done !== 1'b0) $display("FAIL abort_nodone: done=%b required 0", bus.done);
                    else n_pass++;
                    fin = 1;
                end else begin
                    bus.word_ready = 1'b1;
                    last = int'(sb[0].idx) == NW - 1;
                    void'(sb.pop_front());
                    tick();
                    if (last) begin
                        n_total++;
                        if (bus.done !== 1'b1 || bus.word_valid !== 1'b0) begin
                            $display("FAIL done_pulse: done=%b valid=%b required done=1 valid=0", bus.done, bus.word_valid);
                        end else n_pass++;
                        tick();
                        n_total++;
                        if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
                            $display("FAIL done_end: done=%b busy=%b required 0 0", bus.done, bus.busy);
                        end else n_pass++;
                        fin = 1;
                    end
                end
            end
        end
        if (!fin) begin
            n_total++;
            $display("FAIL drain_budget: stream did not finish, required completion");
        end
        sb.delete();
        bus.word_ready = 1'b0;
    endtask
    task automatic test_reset();
        #2;
        n_total++;
        if (bus.busy !== 1'b0 || bus.puf_enable !== 1'b0 || bus.puf_control !== 2'b00 || bus.word_valid !== 1'b0 ||
            bus.done !== 1'b0 || bus.word_data !== '0 || bus.word_index !== '0 || bus.unstable_cnt !== '0) begin
            $display("FAIL reset_state: busy=%b en=%b ctrl=%b valid=%b done=%b data=%h idx=%0d unst=%0d required all 0",
                     bus.busy, bus.puf_enable, bus.puf_control, bus.word_valid, bus.done, bus.word_data, bus.word_index, bus.unstable_cnt);
        end else n_pass++;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
    endtask
    task automatic test_basic();
        launch(2'b10, build(32'hC0DE0000), build(32'hC0DE0000), build(32'hC0DE0000));
        n_total++;
        if (bus.puf_control !== 2'b10) $display("FAIL basic_ctrl: ctrl=%b required 10", bus.puf_control);
        else n_pass++;
        n_total++;
        if (bus.word_valid !== 1'b0 || bus.puf_enable !== 1'b1) begin
            $display("FAIL basic_t17: valid=%b en=%b required valid=0 en=1", bus.word_valid, bus.puf_enable);
        end else n_pass++;
        tick();
        n_total++;
        if (bus.word_valid !== 1'b1 || bus.puf_enable !== 1'b0 || bus.busy !== 1'b1) begin
            $display("FAIL basic_t18: valid=%b en=%b busy=%b required 1 0 1", bus.word_valid, bus.puf_enable, bus.busy);
        end else n_pass++;
        drain(-1, 0, -1);
    endtask
    task automatic test_majority();
        logic [RESP_W-1:0] a, b;
        a = build(32'hC0DE0000);
        b = a;
        a[0] = 1'b1;
        b[1] = 1'b1;
        launch(2'b01, a, b, a);
        tick();
        n_total++;
        if (bus.word_data[1:0] !== 2'b01) $display("FAIL maj_bits: bits=%b required 01", bus.word_data[1:0]);
        else n_pass++;
        n_total++;
        if (int'(bus.unstable_cnt) != EXP_UNST) $display("FAIL maj_unstable: cnt=%0d required %0d", bus.unstable_cnt, EXP_UNST);
        else n_pass++;
        drain(-1, 0, -1);
        n_total++;
        if (int'(bus.unstable_cnt) != EXP_UNST) $display("FAIL maj_unst_hold: cnt=%0d required %0d", bus.unstable_cnt, EXP_UNST);
        else n_pass++;
    endtask
    task automatic test_stall();
        logic [RESP_W-1:0] v;
        v = build(32'h5A5A0100);
        launch(2'b11, v, v, v);
        n_total++;
        if (bus.unstable_cnt !== '0) $display("FAIL stall_unst_clear: cnt=%0d required 0", bus.unstable_cnt);
        else n_pass++;
        tick();
        drain(3, 5, -1);
    endtask
    task automatic test_abort();
        logic [RESP_W-1:0] v;
        v = build(32'hC0DE0000);
        launch(2'b10, v, v, v);
        tick();
        drain(-1, 0, 10);
        v = build(32'h12340000);
        launch(2'b10, v, v, v);
        tick();
        drain(-1, 0, -1);
    endtask
    task automatic test_start_ignored();
        bus.challenge = 2'b11;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        n_total++;
        if (bus.busy !== 1'b1 || bus.puf_control !== 2'b11) $display("FAIL ign_accept: busy=%b ctrl=%b required 1 11", bus.busy, bus.puf_control);
        else n_pass++;
        bus.challenge = 2'b00;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        n_total++;
        if (bus.puf_control !== 2'b11 || bus.puf_enable !== 1'b1) $display("FAIL ign_settle: ctrl=%b en=%b required 11 1", bus.puf_control, bus.puf_enable);
        else n_pass++;
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        n_total++;
        if (bus.busy !== 1'b0) $display("FAIL ign_abort: busy=%b required 0", bus.busy);
        else n_pass++;
        bus.challenge = 2'b01;
        bus.start = 1'b1;
        bus.abort = 1'b1;
        tick();
        n_total++;
        if (bus.busy !== 1'b0 || bus.puf_control !== 2'b11) $display("FAIL ign_both: busy=%b ctrl=%b required 0 11", bus.busy, bus.puf_control);
        else n_pass++;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        tick();
        n_total++;
        if (bus.busy !== 1'b0) $display("FAIL ign_idle: busy=%b required 0", bus.busy);
        else n_pass++;
    endtask
    task automatic test_reset_midcapture();
        logic [RESP_W-1:0] v;
        bus.challenge = 2'b10;
        bus.start = 1'b1;
        bus.puf_response = build(32'hDEAD0000);
        tick();
        bus.start = 1'b0;
        repeat (10) tick();
        n_total++;
        if (bus.puf_enable !== 1'b1) $display("FAIL rst_capture_en: en=%b required 1", bus.puf_enable);
        else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        n_total++;
        if (bus.busy !== 1'b0 || bus.puf_enable !== 1'b0 || bus.puf_control !== 2'b00 || bus.word_valid !== 1'b0 ||
            bus.done !== 1'b0 || bus.word_data !== '0 || bus.word_index !== '0 || bus.unstable_cnt !== '0) begin
            $display("FAIL rst_async: busy=%b en=%b ctrl=%b valid=%b done=%b data=%h idx=%0d required all 0",
                     bus.busy, bus.puf_enable, bus.puf_control, bus.word_valid, bus.done, bus.word_data, bus.word_index);
        end else n_pass++;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        v = build(32'hA5A50000);
        launch(2'b01, v, v, v);
        n_total++;
        if (bus.puf_control !== 2'b01) $display("FAIL rst_ctrl: ctrl=%b required 01", bus.puf_control);
        else n_pass++;
        tick();
        drain(-1, 0, -1);
    endtask
    initial begin
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.challenge = 2'b00;
        bus.word_ready = 1'b0;
        bus.puf_response = '0;
        test_reset();
        test_basic();
        test_majority();
        test_stall();
        test_abort();
        test_start_ignored();
        test_reset_midcapture();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
